// File: rtl/rr_request_arbiter_pkg.sv
// Shared defaults and a small helper for the round-robin request arbiter.
package rr_request_arbiter_pkg;

    localparam int RR_DEFAULT_NUM_REQUEST      = 4;
    localparam int RR_DEFAULT_NUM_REQUEST_LOG2 = 2;
    localparam int RR_DEFAULT_ENTRY_WIDTH      = 32;

    // Index after idx in a ring of num ports (num need not be a power of two).
    function automatic int rr_wrap_next(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_request_arbiter_picker.sv
// Combinational round-robin priority picker: first eligible port at or after
// the pointer, wrapping from NUM_REQUEST-1 back to 0.
module rr_priority_picker #(
    parameter int NUM_REQUEST      = 4,
    parameter int NUM_REQUEST_LOG2 = 2
) (
    input  logic [NUM_REQUEST-1:0]      eligible_in,
    input  logic [NUM_REQUEST_LOG2-1:0] pointer_in,
    output logic [NUM_REQUEST-1:0]      grant_onehot_out,
    output logic [NUM_REQUEST_LOG2-1:0] grant_idx_out,
    output logic                        any_grant_out
);

    // One extra bit so pointer + offset never overflows before the wrap.
    localparam int IDXW = NUM_REQUEST_LOG2 + 1;
    localparam logic [IDXW-1:0] NUM_EXT = IDXW'(NUM_REQUEST);

    logic [IDXW-1:0] cand;

    // Scan offsets 0..N-1 from the pointer; the first eligible candidate wins.
    always_comb begin
        cand             = '0;
        grant_idx_out    = '0;
        any_grant_out    = 1'b0;
        for (int k = 0; k < NUM_REQUEST; k++) begin
            cand = {1'b0, pointer_in} + IDXW'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!any_grant_out && eligible_in[cand[NUM_REQUEST_LOG2-1:0]]) begin
                any_grant_out = 1'b1;
                grant_idx_out = cand[NUM_REQUEST_LOG2-1:0];
            end
        end
        grant_onehot_out = any_grant_out ? (NUM_REQUEST'(1) << grant_idx_out) : '0;
    end

endmodule

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter merging NUM_REQUEST valid/ack sources into one
// registered output entry with a valid/ack handshake toward the queue.
module rr_request_arbiter
    import rr_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUEST                = RR_DEFAULT_NUM_REQUEST,
    parameter int NUM_REQUEST_LOG2           = RR_DEFAULT_NUM_REQUEST_LOG2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = RR_DEFAULT_ENTRY_WIDTH
) (
    input  logic                                              clk_in,
    input  logic                                              reset_in,
    input  logic [NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
    input  logic [NUM_REQUEST-1:0]                            request_valid_packed_in,
    output logic [NUM_REQUEST-1:0]                            issue_ack_packed_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             request_out,
    output logic                                              request_valid_out,
    input  logic                                              issue_ack_in
);

    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    logic [W-1:0]                request_q, request_d;
    logic                        valid_q, valid_d;
    logic [NUM_REQUEST-1:0]      ack_q, ack_d;
    logic [NUM_REQUEST_LOG2-1:0] ptr_q, ptr_d;

    logic [W-1:0]                req_array [NUM_REQUEST];
    logic                        slot_free;
    logic [NUM_REQUEST-1:0]      eligible;
    logic [NUM_REQUEST-1:0]      grant_onehot;
    logic [NUM_REQUEST_LOG2-1:0] grant_idx;
    logic                        any_grant;

    // Unpack the flat request bus into per-source entries.
    for (genvar gi = 0; gi < NUM_REQUEST; gi++) begin : g_unpack
        assign req_array[gi] = request_packed_in[gi*W +: W];
    end

    // The entry can be replaced when empty or being consumed this cycle.
    assign slot_free = !valid_q || issue_ack_in;

    // A source acked this cycle still shows its old data, so it sits out.
    assign eligible = request_valid_packed_in & ~ack_q;

    rr_priority_picker #(
        .NUM_REQUEST      (NUM_REQUEST),
        .NUM_REQUEST_LOG2 (NUM_REQUEST_LOG2)
    ) u_picker (
        .eligible_in      (eligible),
        .pointer_in       (ptr_q),
        .grant_onehot_out (grant_onehot),
        .grant_idx_out    (grant_idx),
        .any_grant_out    (any_grant)
    );

    // Next-state: capture the winner into a free slot, otherwise hold or drain.
    always_comb begin
        request_d = request_q;
        valid_d   = valid_q;
        ack_d     = '0;
        ptr_d     = ptr_q;
        if (slot_free) begin
            if (any_grant) begin
                request_d = req_array[grant_idx];
                valid_d   = 1'b1;
                ack_d     = grant_onehot;
                ptr_d     = NUM_REQUEST_LOG2'(rr_wrap_next(int'(grant_idx), NUM_REQUEST));
            end else begin
                // Free with nothing to take: the old entry was consumed or absent.
                valid_d = 1'b0;
            end
        end
    end

    // State registers; reset drops any held entry immediately.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            request_q <= '0;
            valid_q   <= 1'b0;
            ack_q     <= '0;
            ptr_q     <= '0;
        end else begin
            request_q <= request_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
            ptr_q     <= ptr_d;
        end
    end

    assign request_out          = request_q;
    assign request_valid_out    = valid_q;
    assign issue_ack_packed_out = ack_q;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Bench for rr_request_arbiter: vector table through a scoreboard queue,
// then fairness, backpressure and asynchronous-reset sequences.
module tb_rr_request_arbiter;

    localparam int N    = 4;
    localparam int LOG2 = 2;
    localparam int W    = 32;

    logic           clk_in = 1'b0;
    logic           reset_in = 1'b1;
    logic [N*W-1:0] request_packed_in;
    logic [N-1:0]   request_valid_packed_in = '0;
    logic [N-1:0]   issue_ack_packed_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic           issue_ack_in = 1'b0;

    logic [W-1:0]   src_data [N];

    always #5 clk_in = ~clk_in;

    always_comb begin
        request_packed_in = '0;
        for (int i = 0; i < N; i++) begin
            request_packed_in[i*W +: W] = src_data[i];
        end
    end

    rr_request_arbiter #(
        .NUM_REQUEST                (N),
        .NUM_REQUEST_LOG2           (LOG2),
        .SINGLE_ENTRY_WIDTH_IN_BITS (W)
    ) dut (
        .clk_in                  (clk_in),
        .reset_in                (reset_in),
        .request_packed_in       (request_packed_in),
        .request_valid_packed_in (request_valid_packed_in),
        .issue_ack_packed_out    (issue_ack_packed_out),
        .request_out             (request_out),
        .request_valid_out       (request_valid_out),
        .issue_ack_in            (issue_ack_in)
    );

    typedef struct {
        logic [N-1:0] ack;
        logic         valid;
        logic [W-1:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0] vin;
        logic         ack_in;
        logic [N-1:0] exp_ack;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [13];
    int   checks = 0;
    int   passes = 0;
    logic [N-1:0] prev_ack = '0;

    task automatic check(input string name, input exp_t e);
        checks++;
        if (issue_ack_packed_out === e.ack && request_valid_out === e.valid &&
            request_out === e.data) begin
            passes++;
            $display("ok   %s ack=%b valid=%b data=%h", name,
                     issue_ack_packed_out, request_valid_out, request_out);
        end else begin
            $display("FAIL %s: got ack=%b valid=%b data=%h, want ack=%b valid=%b data=%h",
                     name, issue_ack_packed_out, request_valid_out, request_out,
                     e.ack, e.valid, e.data);
        end
    endtask

    // Push the expectation, clock once, then pop and compare.
    task automatic step(input string name, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        got = sb_q.pop_front();
        check(name, got);
    endtask

    // Source protocol: a port acked in the previous cycle moves to new data.
    task automatic advance_sources();
        for (int i = 0; i < N; i++) begin
            if (prev_ack[i]) src_data[i] = src_data[i] + 32'd4;
        end
        prev_ack = issue_ack_packed_out;
    endtask

    initial begin
        exp_t e;

        // {valid_in, ack_in, exp_ack, exp_valid, exp_data}; port i data = A5A5_000i
        vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'hA5A5_0002};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 32'hA5A5_0002};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'hA5A5_0002};
        vecs[4]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 32'hA5A5_0003};
        vecs[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'hA5A5_0000};
        vecs[6]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 32'hA5A5_0000};
        vecs[7]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 32'hA5A5_0000};
        vecs[8]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 32'hA5A5_0001};
        vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 32'hA5A5_0003};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'hA5A5_0000};
        vecs[11] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 32'hA5A5_0000};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'hA5A5_0000};

        for (int i = 0; i < N; i++) src_data[i] = 32'hA5A5_0000 + W'(i);

        // Reset state
        #2 reset_in = 1'b0;
        #1;
        e = '{4'b0000, 1'b0, 32'h0};
        check("reset_state", e);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;

        // Table: single source, ack masking, pointer wrap, hold
        for (int i = 0; i < 13; i++) begin
            request_valid_packed_in = vecs[i].vin;
            issue_ack_in            = vecs[i].ack_in;
            e = '{vecs[i].exp_ack, vecs[i].exp_valid, vecs[i].exp_data};
            step($sformatf("vec%0d", i), e);
        end

        // Fairness: all ports valid, downstream acks every cycle; pointer starts at 1
        // after the table, so realign by a reset first.
        reset_in = 1'b0;
        #1;
        reset_in = 1'b1;
        for (int i = 0; i < N; i++) src_data[i] = 32'h10 + W'(i);
        prev_ack = '0;
        request_valid_packed_in = 4'b1111;
        issue_ack_in = 1'b1;
        for (int n = 0; n < 12; n++) begin
            e = '{N'(1) << (n % N), 1'b1, 32'h10 + W'(n)};
            step($sformatf("fair%0d", n), e);
            advance_sources();
        end

        // Backpressure: entry 0x1B held, no acks, pointer frozen at 0
        issue_ack_in = 1'b0;
        for (int n = 0; n < 10; n++) begin
            e = '{4'b0000, 1'b1, 32'h1B};
            step($sformatf("bp_hold%0d", n), e);
            advance_sources();
        end
        issue_ack_in = 1'b1;
        e = '{4'b0001, 1'b1, 32'h1C};
        step("bp_pulse", e);
        advance_sources();
        issue_ack_in = 1'b0;
        e = '{4'b0000, 1'b1, 32'h1C};
        step("bp_after", e);

        // Asynchronous reset mid-hold, away from any clock edge
        #2 reset_in = 1'b0;
        #1;
        e = '{4'b0000, 1'b0, 32'h0};
        check("async_reset", e);
        @(negedge clk_in);
        for (int i = 0; i < N; i++) src_data[i] = 32'h10 + W'(i);
        request_valid_packed_in = 4'b1111;
        issue_ack_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b1;
        e = '{4'b0001, 1'b1, 32'h10};
        step("post_reset_grant0", e);
        e = '{4'b0010, 1'b1, 32'h11};
        step("post_reset_grant1", e);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_request_arbiter.md
Name: rr_request_arbiter

Overview:
Round-robin arbiter that merges NUM_REQUEST independent request sources into the single request/ack stream feeding fifo_queue. It sits directly upstream of fifo_queue and drives that block's request_in, request_valid_in and issue_ack_out interface. It holds a one-entry output register and uses the codebase's valid/ack protocol on every port: a source holds valid and data stable until it sees a one-cycle ack pulse, then advances at the next edge.

Parameters:
NUM_REQUEST, 4, number of upstream request sources (>= 2; need not be a power of two)
NUM_REQUEST_LOG2, 2, width of the round-robin pointer; must satisfy 2**NUM_REQUEST_LOG2 >= NUM_REQUEST
SINGLE_ENTRY_WIDTH_IN_BITS, 32, width of one request

Ports:
clk_in  input  1  single clock, all state on posedge
reset_in  input  1  asynchronous, active-low reset (0 = reset)
request_packed_in  input  NUM_REQUEST*SINGLE_ENTRY_WIDTH_IN_BITS  source i occupies bits [i*W +: W]
request_valid_packed_in  input  NUM_REQUEST  bit i = source i holds a valid request
issue_ack_packed_out  output  NUM_REQUEST  bit i = one-cycle pulse: source i's request was accepted
request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  held entry, connects to fifo_queue request_in
request_valid_out  output  1  held entry valid, connects to fifo_queue request_valid_in
issue_ack_in  input  1  downstream consumed request_out this cycle, connects to fifo_queue issue_ack_out

Behaviour:
- Reset (reset_in = 0, asynchronous): request_out = 0, request_valid_out = 0, issue_ack_packed_out = 0, rr pointer = 0. Any held entry is dropped immediately, including during a hold.
- Slot free this cycle = (!request_valid_out) | issue_ack_in. issue_ack_in while request_valid_out = 0 is ignored.
- Eligible(i) = request_valid_packed_in[i] & !issue_ack_packed_out[i]. A port acked in the current cycle still presents its old data, so it is masked for that cycle to prevent duplicate capture.
- Grant: if the slot is free and any port is eligible, select the first eligible port scanning pointer, pointer+1, ... with wrap from NUM_REQUEST-1 to 0.
- At the same posedge, the grant causes:
  - request_out <= winner's data
  - request_valid_out <= 1
  - issue_ack_packed_out <= onehot(winner); this is a one-cycle pulse
  - pointer <= winner+1, wrapping to 0 after NUM_REQUEST-1.
- Slot free but no port eligible: request_valid_out <= 0 only if issue_ack_in consumed the entry; request_out keeps its last value; acks <= 0; pointer unchanged.
- Slot not free (valid and no issue_ack_in): request_out and request_valid_out hold; acks <= 0; pointer unchanged.
- Latency: source valid to ack pulse is 1 cycle when the slot is free. The captured data appears on request_out in the same cycle as the ack.
- Throughput: one entry per cycle when downstream acks every cycle. A single port sustains at most one entry every 2 cycles because of the ack mask.
- At most one bit of issue_ack_packed_out is ever set.
- Sources are never acked without their data having been captured.

Decomposition:
- Shared header parameters.h: default widths and an optional NUM_REQUEST default. No typedefs are needed.
- One natural sub-module, rr_priority_picker. It is combinational: inputs are the eligible mask and the pointer; outputs are onehot grant, grant index and any_grant.
- The register stage, masking and pointer update stay in rr_request_arbiter.

Test Plan:
1. Reset: drive reset_in = 0 mid-hold with request_valid_out = 1 -> request_valid_out, request_out and issue_ack_packed_out all 0 immediately (asynchronously); after release, first grant goes to port 0 when all ports are valid.
2. Single source: port 2 holds 0xA5A5_0002 valid and issue_ack_in = 1 every cycle -> issue_ack_packed_out = 4'b0100 for exactly one cycle; request_out = 0xA5A5_0002 with valid = 1 in that same cycle; no second grant to port 2 in the ack cycle.
3. Fairness: all four ports valid (data 0x10 + i), each advancing its data on ack, issue_ack_in = 1 every cycle -> request_out sequence 0x10, 0x11, 0x12, 0x13 from ports 0, 1, 2, 3, then wraps to port 0; one grant per cycle.
4. Backpressure: issue_ack_in = 0 for 10 cycles with all ports valid -> request_out stable, no ack bits set, pointer frozen; a single issue_ack_in pulse -> exactly one new grant, to the next port in rotation.
5. Pointer wrap: last winner port 3, then only ports 0 and 3 valid -> port 0 wins; pointer becomes 1.
6. End to end: connect to fifo_queue (QUEUE_SIZE 16), 4 sources sending distinct incrementing values, fifo drained every 16 cycles -> the fifo never receives a duplicate or a lost value; per-source order is preserved.
